// File: rtl/dac_fifo_if.sv
// Avalon-MM register bus between the HPS lightweight bridge and dac_fifo.
interface dac_fifo_if;
  logic [1:0]  addr;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output addr, read, write, writedata, input readdata);
  modport slave  (input addr, read, write, writedata, output readdata);
endinterface

// File: rtl/dac_fifo.sv
// dac_fifo: CPU-fed sample FIFO drained at a programmed rate as 16-bit SPI
// frames {0, ch[2:0], sample[11:0]} to an 8-channel 12-bit DAC.
// Optional feature macro DAC_FIFO_CH_TAG_EN: each FIFO entry carries its own
// channel (DATA[14:12]) and STATUS[23:21] shows the last popped channel.
module dac_fifo #(
  parameter int unsigned FIFO_AW  = 8,
  parameter int unsigned SCK_HALF = 2
) (
  input  logic      clock,
  input  logic      reset_n,
  dac_fifo_if.slave bus,
  output logic      DAC_CS_N_o,
  output logic      DAC_SCK_o,
  output logic      DAC_SDI_o
);
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned HW    = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
`ifdef DAC_FIFO_CH_TAG_EN
  localparam int unsigned DW    = 15;
`else
  localparam int unsigned DW    = 12;
`endif

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT_HI, S_SHIFT_LO, S_HOLD} state_e;

  logic              enable_q, enable_d;
  logic [2:0]        ch_q, ch_d;
  logic [15:0]       rate_q, rate_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              underrun_q, underrun_d, overflow_q, overflow_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [DW-1:0]     mem_q [DEPTH];
  state_e            state_q, state_d;
  logic [HW-1:0]     half_q, half_d;
  logic [3:0]        bit_q, bit_d;
  logic [15:0]       shreg_q, shreg_d;
  logic              cs_n_q, cs_n_d, sck_q, sck_d, sdi_q, sdi_d;

  logic wr_ctrl_c, wr_rate_c, wr_data_c, wr_stat_c, clear_c;
  logic empty_c, full_c, idle_c, tick_c, pop_c, push_c, half_done_c;
  logic [DW-1:0] rd_word_c;
  logic [2:0]    frame_ch_c;
  logic [31:0]   status_c;
  logic          unused_bits_c;

  assign wr_ctrl_c   = bus.write && (bus.addr == 2'd0);
  assign wr_rate_c   = bus.write && (bus.addr == 2'd1);
  assign wr_data_c   = bus.write && (bus.addr == 2'd2);
  assign wr_stat_c   = bus.write && (bus.addr == 2'd3);
  assign clear_c     = wr_ctrl_c && bus.writedata[1];
  assign empty_c     = (level_q == '0);
  assign full_c      = (level_q == LW'(DEPTH));
  assign idle_c      = (state_q == S_IDLE);
  assign tick_c      = enable_q && (cnt_q == rate_q);
  assign pop_c       = tick_c && !empty_c && idle_c;
  // A pop in the same cycle frees the slot the write lands in.
  assign push_c      = wr_data_c && !clear_c && (!full_c || pop_c);
  assign rd_word_c   = mem_q[rd_ptr_q];
  assign half_done_c = (half_q == HW'(SCK_HALF - 1));
  assign unused_bits_c = ^{bus.writedata[31:20], bus.writedata[17:16]};

`ifdef DAC_FIFO_CH_TAG_EN
  logic [2:0] last_ch_q, last_ch_d;
  assign frame_ch_c = rd_word_c[14:12];
  assign last_ch_d  = pop_c ? rd_word_c[14:12] : last_ch_q;

  // Channel of the most recently popped entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_ch_q <= '0;
    else          last_ch_q <= last_ch_d;
  end
`else
  assign frame_ch_c = ch_q;
`endif

  // STATUS register image.
  always_comb begin
    status_c           = '0;
    status_c[LW-1:0]   = level_q;
    status_c[16]       = empty_c;
    status_c[17]       = full_c;
    status_c[18]       = underrun_q;
    status_c[19]       = overflow_q;
    status_c[20]       = !idle_c;
`ifdef DAC_FIFO_CH_TAG_EN
    status_c[23:21]    = last_ch_q;
`endif
  end

  // Registers, rate counter, FIFO pointers, flags and read mux.
  always_comb begin
    enable_d   = enable_q;
    ch_d       = ch_q;
    rate_d     = rate_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    readdata_d = readdata_q;

    if (wr_ctrl_c) begin
      enable_d = bus.writedata[0];
      ch_d     = bus.writedata[6:4];
    end
    if (wr_rate_c) rate_d = bus.writedata[15:0];

    if (!enable_q)   cnt_d = '0;
    else if (tick_c) cnt_d = '0;
    else             cnt_d = cnt_q + 16'd1;

    if (push_c) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (clear_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    // Setting a flag wins over a same-cycle software clear.
    if (wr_stat_c && bus.writedata[18]) underrun_d = 1'b0;
    if (wr_stat_c && bus.writedata[19]) overflow_d = 1'b0;
    if (tick_c && (empty_c || !idle_c)) underrun_d = 1'b1;
    if (wr_data_c && !clear_c && !push_c) overflow_d = 1'b1;

    if (bus.read) begin
      case (bus.addr)
        2'd0:    readdata_d = 32'({ch_q, 3'b000, enable_q});
        2'd1:    readdata_d = 32'(rate_q);
        2'd2:    readdata_d = '0;
        default: readdata_d = status_c;
      endcase
    end
  end

  // Control/status flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= 1'b0;
      ch_q       <= '0;
      rate_q     <= 16'd999;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      enable_q   <= enable_d;
      ch_q       <= ch_d;
      rate_q     <= rate_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      readdata_q <= readdata_d;
    end
  end

  // Sample storage; contents need no reset.
  always_ff @(posedge clock) begin
    if (push_c) mem_q[wr_ptr_q] <= bus.writedata[DW-1:0];
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state plus half-period, bit counter and shift register.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    half_d  = (idle_c || half_done_c) ? '0 : half_q + HW'(1);
    case (state_q)
      S_IDLE: begin
        if (pop_c) begin
          state_d = S_SETUP;
          bit_d   = '0;
          shreg_d = {1'b0, frame_ch_c, rd_word_c[11:0]};
        end
      end
      S_SETUP: if (half_done_c) state_d = S_SHIFT_HI;
      S_SHIFT_HI: begin
        if (half_done_c) begin
          state_d = S_SHIFT_LO;
          shreg_d = {shreg_q[14:0], 1'b0};
        end
      end
      S_SHIFT_LO: begin
        if (half_done_c) begin
          if (bit_q == 4'd15) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_SHIFT_HI;
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      S_HOLD:  if (half_done_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin levels for the upcoming state, registered below.
  always_comb begin
    cs_n_d = 1'b1;
    sck_d  = 1'b0;
    sdi_d  = 1'b0;
    case (state_d)
      S_SETUP, S_SHIFT_LO: begin
        cs_n_d = 1'b0;
        sdi_d  = shreg_d[15];
      end
      S_SHIFT_HI: begin
        cs_n_d = 1'b0;
        sck_d  = 1'b1;
        sdi_d  = shreg_d[15];
      end
      default: ;
    endcase
  end

  // Frame datapath and SPI pin flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      half_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      sdi_q   <= 1'b0;
    end else begin
      half_q  <= half_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      sdi_q   <= sdi_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign DAC_CS_N_o   = cs_n_q;
  assign DAC_SCK_o    = sck_q;
  assign DAC_SDI_o    = sdi_q;
endmodule

// File: tb/tb_dac_fifo.sv
// Directed bench for dac_fifo: register access, frame shape, rate, FIFO
// full/overflow, fast-rate underrun, clear mid-frame and async reset.
module tb_dac_fifo;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic cs_n, sck, sdi;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   wr_cyc = 0;
  logic [31:0] rdv;

`ifdef DAC_FIFO_CH_TAG_EN
  localparam logic [31:0] LCH = 32'h00A0_0000;
`else
  localparam logic [31:0] LCH = 32'h0000_0000;
`endif

  dac_fifo_if bus ();

  dac_fifo #(.FIFO_AW(2), .SCK_HALF(2)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .DAC_CS_N_o(cs_n), .DAC_SCK_o(sck), .DAC_SDI_o(sdi)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Frame monitor: captures SDI on SCK rising edges while CS_N is low.
  logic        in_frame = 1'b0, prev_sck = 1'b0;
  logic [15:0] cur_word = '0;
  int          cur_len = 0, cur_edges = 0, cur_fall = 0;
  logic [15:0] frm_q[$];
  int          len_q[$], edg_q[$], fall_q[$];

  always @(negedge clock) begin
    if (!reset_n) begin
      in_frame <= 1'b0;
      prev_sck <= 1'b0;
    end else begin
      if (!cs_n) begin
        if (!in_frame) begin
          in_frame  <= 1'b1;
          cur_len   <= 1;
          cur_edges <= 0;
          cur_word  <= '0;
          cur_fall  <= cyc;
        end else begin
          cur_len <= cur_len + 1;
          if (sck && !prev_sck) begin
            cur_word  <= {cur_word[14:0], sdi};
            cur_edges <= cur_edges + 1;
          end
        end
      end else if (in_frame) begin
        in_frame <= 1'b0;
        frm_q.push_back(cur_word);
        len_q.push_back(cur_len);
        edg_q.push_back(cur_edges);
        fall_q.push_back(cur_fall);
      end
      prev_sck <= sck;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clock);
    wr_cyc        = cyc;
    bus.write     = 1'b1;
    bus.addr      = a;
    bus.writedata = d;
    @(negedge clock);
    bus.write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clock);
    bus.read = 1'b1;
    bus.addr = a;
    @(negedge clock);
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frm_q.size() < n; i++) @(negedge clock);
  endtask

  task automatic clear_log();
    frm_q.delete(); len_q.delete(); edg_q.delete(); fall_q.delete();
  endtask

  initial begin
    bus.addr = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    repeat (3) @(negedge clock);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_sdi", 32'(sdi), 32'd0);
    chk("rst_rdata", bus.readdata, 32'd0);
    reset_n = 1'b1;
    rd(2'd1, rdv); chk("rst_rate", rdv, 32'd999);
    rd(2'd3, rdv); chk("rst_status", rdv, 32'h0001_0000);
    rd(2'd0, rdv); chk("rst_ctrl", rdv, 32'd0);

    // Basic frame: RATE=99, ch=5, sample 0xABC.
    wr(2'd1, 32'd99);
    wr(2'd0, 32'h50);
    wr(2'd2, 32'h5ABC);
    rd(2'd3, rdv); chk("basic_level1", rdv, 32'h0000_0001);
    wr(2'd0, 32'h51);
    begin
      int en_cyc;
      en_cyc = wr_cyc;
      wait_frames(1, 400);
      wr(2'd0, 32'h50);
      chk("basic_count", 32'(frm_q.size()), 32'd1);
      if (frm_q.size() >= 1) begin
        chk("basic_word", 32'(frm_q[0]), 32'h5ABC);
        chk("basic_edges", 32'(edg_q[0]), 32'd16);
        chk("basic_cs_len", 32'(len_q[0]), 32'd66);
        chk("basic_fall", 32'(fall_q[0] - en_cyc), 32'd101);
      end
    end
    repeat (4) @(negedge clock);
    rd(2'd3, rdv); chk("basic_status_idle", rdv, 32'h0001_0000 | LCH);

    // Rate and ordering: three words at RATE=199.
    clear_log();
    wr(2'd1, 32'd199);
    wr(2'd2, 32'h5001);
    wr(2'd2, 32'h5002);
    wr(2'd2, 32'h5003);
    wr(2'd0, 32'h51);
    wait_frames(3, 1000);
    chk("rate_count", 32'(frm_q.size()), 32'd3);
    if (frm_q.size() >= 3) begin
      chk("rate_word0", 32'(frm_q[0]), 32'h5001);
      chk("rate_word1", 32'(frm_q[1]), 32'h5002);
      chk("rate_word2", 32'(frm_q[2]), 32'h5003);
      chk("rate_gap01", 32'(fall_q[1] - fall_q[0]), 32'd200);
      chk("rate_gap12", 32'(fall_q[2] - fall_q[1]), 32'd200);
      while (cyc < fall_q[2] + 205) @(negedge clock);
    end
    rd(2'd3, rdv); chk("rate_underrun", rdv, 32'h0005_0000 | LCH);
    wr(2'd0, 32'h50);
    chk("rate_no_extra", 32'(frm_q.size()), 32'd3);
    wr(2'd3, 32'h0004_0000);
    rd(2'd3, rdv); chk("rate_unflag", rdv, 32'h0001_0000 | LCH);

    // Full/overflow with depth 4: fifth word dropped.
    clear_log();
    wr(2'd2, 32'h5111);
    wr(2'd2, 32'h5222);
    wr(2'd2, 32'h5333);
    wr(2'd2, 32'h5444);
    wr(2'd2, 32'h5555);
    rd(2'd3, rdv); chk("ovf_status", rdv, 32'h000A_0004 | LCH);
    wr(2'd3, 32'h0008_0000);
    rd(2'd3, rdv); chk("ovf_cleared", rdv, 32'h0002_0004 | LCH);
    wr(2'd1, 32'd99);
    wr(2'd0, 32'h51);
    wait_frames(4, 800);
    repeat (250) @(negedge clock);
    wr(2'd0, 32'h50);
    chk("ovf_count", 32'(frm_q.size()), 32'd4);
    if (frm_q.size() >= 4) begin
      chk("ovf_word0", 32'(frm_q[0]), 32'h5111);
      chk("ovf_word3", 32'(frm_q[3]), 32'h5444);
    end
    wr(2'd3, 32'h000C_0000);

    // Too-fast rate: RATE=10 gives one frame every 77 clocks.
    clear_log();
    wr(2'd1, 32'd10);
    wr(2'd2, 32'h50AA);
    wr(2'd2, 32'h50BB);
    wr(2'd2, 32'h50CC);
    wr(2'd0, 32'h51);
    wait_frames(3, 600);
    repeat (5) @(negedge clock);
    wr(2'd0, 32'h50);
    chk("fast_count", 32'(frm_q.size()), 32'd3);
    if (frm_q.size() >= 3) begin
      chk("fast_word2", 32'(frm_q[2]), 32'h50CC);
      chk("fast_len1", 32'(len_q[1]), 32'd66);
      chk("fast_edges2", 32'(edg_q[2]), 32'd16);
      chk("fast_gap", 32'(fall_q[1] - fall_q[0]), 32'd77);
    end
    rd(2'd3, rdv); chk("fast_underrun", rdv, 32'h0005_0000 | LCH);
    wr(2'd3, 32'h000C_0000);

    // Clear while a frame is in flight with three words queued.
    clear_log();
    wr(2'd1, 32'd99);
    wr(2'd2, 32'h5101);
    wr(2'd2, 32'h5102);
    wr(2'd2, 32'h5103);
    wr(2'd2, 32'h5104);
    wr(2'd0, 32'h51);
    for (int i = 0; i < 300 && cs_n; i++) @(negedge clock);
    chk("clr_started", 32'(cs_n), 32'd0);
    wr(2'd0, 32'h53);
    rd(2'd3, rdv); chk("clr_status_busy", rdv, 32'h0011_0000 | LCH);
    repeat (350) @(negedge clock);
    chk("clr_count", 32'(frm_q.size()), 32'd1);
    if (frm_q.size() >= 1) begin
      chk("clr_word", 32'(frm_q[0]), 32'h5101);
      chk("clr_len", 32'(len_q[0]), 32'd66);
    end
    rd(2'd3, rdv); chk("clr_status_end", rdv, 32'h0005_0000 | LCH);
    rd(2'd0, rdv); chk("clr_ctrl_rb", rdv, 32'h51);
    wr(2'd0, 32'h50);
    wr(2'd3, 32'h000C_0000);

    // Async reset during the shift phase.
    clear_log();
    wr(2'd2, 32'h5777);
    wr(2'd0, 32'h51);
    for (int i = 0; i < 300 && !sck; i++) @(negedge clock);
    chk("ar_in_shift", 32'(sck), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_cs_n", 32'(cs_n), 32'd1);
    chk("ar_sck", 32'(sck), 32'd0);
    chk("ar_sdi", 32'(sdi), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    rd(2'd1, rdv); chk("ar_rate", rdv, 32'd999);
    rd(2'd3, rdv); chk("ar_status", rdv, 32'h0001_0000);
    repeat (100) @(negedge clock);
    chk("ar_no_frame", 32'(frm_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dac_fifo.md
# dac_fifo

Avalon-MM slave that buffers CPU-written DAC samples in an on-chip FIFO and drains them at a programmed sample rate as 16-bit SPI frames to an external 8-channel 12-bit DAC. It is the output-direction counterpart of the ADC acquisition path and sits on the same HPS lightweight bus next to it. The block is single clock domain (`clock`), and the SPI clock is derived by division.

## Interface
- `FIFO_AW`, 8: FIFO address width; depth is 2^FIFO_AW words.
- `SCK_HALF`, 2: SCK half-period in `clock` cycles; must be at least 1.
- `clock` in 1: system and bus clock.
- `reset_n` in 1: asynchronous, active-low reset. The clock is `clock`.
- `addr` in 2: register select.
- `read` in 1: bus read strobe. Read latency is 1.
- `write` in 1: bus write strobe, one cycle per access.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `DAC_CS_N_o` out 1: frame select, active low.
- `DAC_SCK_o` out 1: SPI clock, idle low. The DAC samples on the rising edge.
- `DAC_SDI_o` out 1: serial data, MSB first.

## Operation
- Registers:
  - addr0 CTRL (R/W): [0] enable; [6:4] ch; [1] clear (write-1 pulse, reads 0).
  - addr1 RATE (R/W): [15:0]. The sample period is RATE+1 clocks.
  - addr2 DATA (W): [11:0] sample pushed to the FIFO. Reads return 0.
  - addr3 STATUS (R): [FIFO_AW:0] level; [16] empty; [17] full; [18] underrun; [19] overflow; [20] busy.
  - addr3 (W): writing 1 to [18] or [19] clears that flag.
- Reset values: enable=0, ch=0, RATE=999, FIFO empty, flags=0, readdata=0, DAC_CS_N_o=1, DAC_SCK_o=0, DAC_SDI_o=0.
- Rate counter:
  - While enable=1, it counts 0..RATE and wraps.
  - The cycle where the count equals RATE is a tick.
  - While enable=0, the counter is held at 0.
- On a tick:
  - If the FIFO is non-empty and the FSM is IDLE: pop one word and start a frame.
  - If the FIFO is empty: set underrun. No frame is sent and the DAC holds its last value.
  - If the FSM is not IDLE: the tick is ignored, and underrun is set.
- Frame word: {1'b0, ch[2:0], sample[11:0]}.
- FSM states:
  - IDLE: CS_N=1, SCK=0. Moves to SETUP on a pop.
  - SETUP: CS_N=0, SDI=bit15, SCK=0, for SCK_HALF clocks.
  - SHIFT: 16 bits. Each bit drives SCK=1 for SCK_HALF clocks, then SCK=0 for SCK_HALF clocks. SDI advances to the next bit on the SCK falling edge.
  - HOLD: after the 16th falling edge, CS_N=1 and SDI=0 for SCK_HALF clocks, then return to IDLE.
- busy=1 in every state except IDLE.
- FIFO writes:
  - A DATA write is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the write is dropped and overflow is set.
  - A simultaneous push and pop leaves the level unchanged.
- Clear: empties the FIFO in the same cycle. An in-flight frame completes unchanged, and a DATA write in that same cycle is discarded.
- Disable mid-frame: the frame completes and no further ticks occur.
- reset_n asserted mid-frame: all outputs return to reset values immediately, and the frame is abandoned.

## Timing
- Tick at cycle T: the pop happens at T, and DAC_CS_N_o falls at T+1.
- Frame duration: CS_N is low for exactly 33*SCK_HALF clocks.
- IDLE is re-entered at T+1+34*SCK_HALF.
- Minimum legal RATE is 34*SCK_HALF. Smaller values produce ignored ticks and set underrun.
- Register read: addr sampled with read at cycle C, readdata valid at C+1. readdata holds its value otherwise.
- Register write: takes effect at the cycle after the `write` strobe. A new RATE applies when the counter is next compared.
- Level and flags are readable one cycle after the causing event.

## Configuration
- `DAC_FIFO_CH_TAG_EN` defined:
  - FIFO entries are 15 bits wide and DATA[14:12] is stored with each sample.
  - The frame uses the per-entry channel, and CTRL.ch is ignored for frames.
  - STATUS[23:21] shows the channel of the last popped entry.
- `DAC_FIFO_CH_TAG_EN` undefined:
  - FIFO entries are 12 bits; DATA[14:12] is ignored.
  - Every frame uses CTRL.ch.
  - STATUS[23:21] reads 0.

## Test plan
- Basic frame: SCK_HALF=2, RATE=99, ch=5. Push 0xABC, then enable. The first tick is at count 99, and 16 rising edges must carry 0x5ABC MSB-first. CS_N is low for 66 clocks.
- Rate and ordering: push 0x001, 0x002, 0x003 with RATE=199. CS_N must fall at exactly 200-clock spacing, carrying data 1, 2, 3 in order. After the FIFO drains, the next tick sets underrun and STATUS shows level=0, empty=1.
- Full and overflow (FIFO_AW=2): push 5 words with enable=0. Level reads 4, full=1, overflow=1, and the 5th word never appears on SDI. Writing addr3 with bit19 set clears overflow.
- Too-fast rate: SCK_HALF=2, RATE=10. Only every other tick, or fewer, starts a frame; underrun is set, and no frame is truncated.
- Clear mid-frame: write CTRL.clear while busy with 3 words queued. The current frame completes intact, the level reads 0 the next cycle, and no further frames are sent.
- Async reset mid-SHIFT: CS_N=1, SCK=0, SDI=0 immediately. After release, RATE reads 999 and STATUS reads empty=1 with all flags clear.
